// File: rtl/ins_mem_arbiter.sv
// ins_mem_arbiter: round-robin sharing of instruction BRAM port B between fetch and loader
// Ports: clk_i/reset_i; fetch read port f_*; loader read/write port l_* with l_lock_i;
// BRAM port-B drive ins_mem_*_o and BRAM status/data ins_mem_rstb_busy_i, ins_mem_doutb_i.
module ins_mem_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,
  output logic [31:0] f_rdata_o,
  input  logic        l_req_i,
  input  logic        l_we_i,
  input  logic [31:0] l_addr_i,
  input  logic [31:0] l_wdata_i,
  output logic        l_gnt_o,
  output logic        l_rvalid_o,
  output logic [31:0] l_rdata_o,
  input  logic        l_lock_i,
  output logic        ins_mem_clkb_o,
  output logic        ins_mem_enb_o,
  output logic        ins_mem_rstb_o,
  output logic [3:0]  ins_mem_web_o,
  output logic [31:0] ins_mem_addrb_o,
  output logic [31:0] ins_mem_dinb_o,
  input  logic        ins_mem_rstb_busy_i,
  input  logic [31:0] ins_mem_doutb_i
);
  logic prio_q, prio_d;
  logic [READ_LAT-1:0] vld_q, own_q;
  logic f_el, l_el, wr, rd, tail;
  assign f_el = f_req_i & ~l_lock_i & ~reset_i & ~ins_mem_rstb_busy_i;
  assign l_el = l_req_i & ~reset_i & ~ins_mem_rstb_busy_i;
  // prio_q=1 means the loader wins a tie
  assign f_gnt_o = f_el & (~l_el | ~prio_q);
  assign l_gnt_o = l_el & (~f_el | prio_q);
  assign wr = l_gnt_o & l_we_i;
  assign rd = f_gnt_o | (l_gnt_o & ~l_we_i);
  always_comb prio_d = f_gnt_o ? 1'b1 : l_gnt_o ? 1'b0 : prio_q;
  assign ins_mem_clkb_o  = clk_i;
  assign ins_mem_rstb_o  = 1'b0;
  assign ins_mem_enb_o   = f_gnt_o | l_gnt_o;
  assign ins_mem_addrb_o = f_gnt_o ? f_addr_i : l_gnt_o ? l_addr_i : 32'h0;
  assign ins_mem_web_o   = {4{wr}};
  assign ins_mem_dinb_o  = wr ? l_wdata_i : 32'h0;
  // owner bit: 1 = loader; the oldest read sits at the top of the shift register
  assign tail       = vld_q[READ_LAT-1] & ~reset_i;
  assign f_rvalid_o = tail & ~own_q[READ_LAT-1];
  assign l_rvalid_o = tail & own_q[READ_LAT-1];
  assign f_rdata_o  = f_rvalid_o ? ins_mem_doutb_i : 32'h0;
  assign l_rdata_o  = l_rvalid_o ? ins_mem_doutb_i : 32'h0;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= 1'b0;
      vld_q  <= '0;
      own_q  <= '0;
    end else begin
      prio_q <= prio_d;
      vld_q  <= (vld_q << 1) | READ_LAT'(rd);
      own_q  <= (own_q << 1) | READ_LAT'(l_gnt_o);
    end
  end
endmodule

// File: doc/ins_mem_arbiter.md
# ins_mem_arbiter

Shares the single port B of the instruction BRAM between the core's fetch stage and the program loader (debug/UART path), driving the BRAM port signals directly. It arbitrates round-robin per cycle and tracks read ownership through the BRAM read latency. Read data is returned only to the requester that issued the read. A lock input lets the loader own the memory exclusively during program download.

## Interface
- READ_LAT, 1: BRAM port-B read latency in cycles; legal values 1..3.
- clk  in  1  system clock; also forwarded as ins_mem_clkb.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address, word-aligned.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) or read (0).
- l_addr  in  32  loader byte address, word-aligned.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  32  loader read data.
- l_lock  in  1  while high, fetch is never granted.
- ins_mem_clkb, ins_mem_enb, ins_mem_rstb  out  1 each  BRAM port-B clock, enable and reset; ins_mem_rstb is constant 0.
- ins_mem_web  out  4  BRAM byte write enables.
- ins_mem_addrb, ins_mem_dinb  out  32 each  BRAM address and write data.
- ins_mem_rstb_busy  in  1  BRAM reset busy.
- ins_mem_doutb  in  32  BRAM read data.

## Operation
- Eligibility:
  - No grant while reset or ins_mem_rstb_busy is high.
  - Fetch is eligible only when l_lock is 0.
- Arbitration:
  - Combinational. At most one grant per cycle.
  - If one requester is eligible, it wins.
  - If both are eligible, the side named by register `prio` wins. prio=0 means fetch preferred.
  - After any grant, prio points at the other requester.
- Granted cycle:
  - ins_mem_enb=1.
  - ins_mem_addrb = granted address.
  - ins_mem_web = 4'hF for a loader write, otherwise 0.
  - ins_mem_dinb = l_wdata for a loader write, otherwise 0.
- No grant: enb=0, web=0, addrb=0, dinb=0.
- Read tracking: each granted read pushes {valid=1, owner} into a READ_LAT-deep shift register; a write or idle cycle pushes valid=0.
- Read return: when the tail entry is valid, the owner's rvalid pulses for one cycle and its rdata is driven from ins_mem_doutb.
- Idle rdata: f_rdata and l_rdata are 0 when their rvalid is low.
- Loader writes produce no rvalid. l_gnt is the write acknowledgement.
- Requesters hold req and addr (and l_we, l_wdata) stable until gnt. A dropped request is simply not served.

## Timing
- Reset values: prio=0, tracking pipeline cleared, all gnt and rvalid outputs 0, enb=0, web=0.
- Grant and BRAM command occur in the same cycle as the request (combinational path from req to gnt and to the BRAM port).
- A read granted in cycle N returns rvalid in cycle N+READ_LAT.
- Full-rate operation: back-to-back reads from either side sustain one per cycle.
- Ordering: returns are in issue order. A fetch return and a loader return never coincide because only one issue happens per cycle.
- Reset mid-operation: the pipeline is flushed. No rvalid is asserted for reads issued before reset, even if BRAM data arrives later.
- rstb_busy rising mid-operation: new grants stop; reads already in flight still complete.
- l_lock rising: takes effect the same cycle. In-flight fetch reads still return. l_lock does not change prio.
- Simultaneous write and read are impossible by construction (one grant per cycle).

## Test plan
- Reset, then f_req=1 with f_addr=0x0, 0x4, 0x8 on successive cycles (BRAM preloaded) -> f_gnt=1 each cycle; f_rvalid at cycles +READ_LAT with the words stored at 0x0, 0x4, 0x8; all loader outputs stay 0.
- Both requesters hold req continuously for 6 cycles -> grants alternate F,L,F,L,F,L starting with fetch; each rvalid is routed to the correct owner.
- l_lock=1, loader writes 0xDEADBEEF to 0x10 while f_req=1 -> f_gnt stays 0; web=0xF, addrb=0x10, dinb=0xDEADBEEF. Then a loader read of 0x10 -> l_rdata=0xDEADBEEF after READ_LAT cycles.
- ins_mem_rstb_busy=1 for 3 cycles with both requesting -> no grants and enb=0; the first grant comes in the cycle busy falls, and it goes to the side named by prio.
- Read issued, then reset asserted in the next cycle (READ_LAT=2) -> no f_rvalid or l_rvalid after reset; prio=0 after reset.
- READ_LAT=3 with an interleaved loader read, write and fetch read -> exactly two rvalid pulses, 3 cycles after their respective grants, each to the correct owner.
